// File: rtl/ip_packet_rx_if.sv
// MAC byte stream in, parsed sender/message result out, for the IPv4 receive path.
// Guarded by IP_RX_CHECKSUM_EN in the consumer module; the interface itself is fixed.
// slave = receiver block view, master = MAC/accelerator (testbench) view.
interface ip_packet_rx_if;
  logic [7:0]  MAC_DATA_IN;
  logic        MAC_DATA_VALID;
  logic        MAC_DATA_READY;
  logic        MAC_DATA_FIRST;
  logic        MAC_DATA_LAST;
  logic [47:0] SENDER_MAC_ADDRESS;
  logic [31:0] SENDER_IP_ADDRESS;
  logic [9:0]  SENDER_MESSAGE;
  logic        MESSAGE_VALID;
  logic        MESSAGE_ACCEPT;
  logic        PACKET_DROPPED;

  modport slave (
    input  MAC_DATA_IN, MAC_DATA_VALID, MAC_DATA_FIRST, MAC_DATA_LAST, MESSAGE_ACCEPT,
    output MAC_DATA_READY, SENDER_MAC_ADDRESS, SENDER_IP_ADDRESS, SENDER_MESSAGE,
           MESSAGE_VALID, PACKET_DROPPED
  );

  modport master (
    output MAC_DATA_IN, MAC_DATA_VALID, MAC_DATA_FIRST, MAC_DATA_LAST, MESSAGE_ACCEPT,
    input  MAC_DATA_READY, SENDER_MAC_ADDRESS, SENDER_IP_ADDRESS, SENDER_MESSAGE,
           MESSAGE_VALID, PACKET_DROPPED
  );
endinterface

// File: rtl/ip_packet_rx.sv
// IPv4 frame receiver: filters Eth/IPv4 frames for this node, extracts sender MAC/IP and 10-bit message.
// Latency: MESSAGE_VALID / PACKET_DROPPED one cycle after the LAST beat.
// Backpressure: MAC_DATA_READY low while a result is held; optional header checksum via IP_RX_CHECKSUM_EN.
module ip_packet_rx #(
  parameter logic [15:0] ETHERTYPE        = 16'h0800,
  parameter logic [7:0]  IP_PROTOCOL      = 8'hFD,
  parameter bit          ACCEPT_BROADCAST = 1'b1
) (
  input  logic        aclk,
  input  logic        areset,
  input  logic [31:0] ACCELERATOR_IP_ADDRESS,
  input  logic [47:0] ACCELERATOR_MAC_ADDRESS,
  ip_packet_rx_if.slave rx
);

  typedef enum logic [2:0] {IDLE, ETH_HDR, IP_HDR, USER_DATA, DROP, HOLD} state_t;

  state_t      state_q, state_d, sec;
  logic [5:0]  cnt_q, cnt_d, idx, idx_inc;
  logic [1:0]  cand_q, cand_d, cand_in, cand_byte;  // [1] own address still possible, [0] broadcast still possible
  logic [7:0]  own_b;
  logic        beat, addr_byte, bad, csum_bad, hold_load, drop_d, drop_q;
  logic [47:0] smac_sh_q, smac_q;
  logic [31:0] sip_sh_q, sip_q;
  logic [1:0]  p0_q;
  logic [7:0]  p1_q;
  logic [9:0]  msg_q;

  assign beat = rx.MAC_DATA_VALID && rx.MAC_DATA_READY;

  // Locate the current byte: a FIRST beat always restarts as Ethernet byte 0
  always_comb begin
    sec     = state_q;
    idx     = cnt_q;
    if (rx.MAC_DATA_FIRST) begin
      sec = ETH_HDR;
      idx = 6'd0;
    end
    idx_inc = (idx == 6'd63) ? idx : idx + 6'd1;
  end

  // Destination address matching, byte by byte against own and broadcast addresses
  always_comb begin
    own_b = 8'h00;
    if (sec == ETH_HDR) begin
      case (idx[2:0])
        3'd0:    own_b = ACCELERATOR_MAC_ADDRESS[47:40];
        3'd1:    own_b = ACCELERATOR_MAC_ADDRESS[39:32];
        3'd2:    own_b = ACCELERATOR_MAC_ADDRESS[31:24];
        3'd3:    own_b = ACCELERATOR_MAC_ADDRESS[23:16];
        3'd4:    own_b = ACCELERATOR_MAC_ADDRESS[15:8];
        default: own_b = ACCELERATOR_MAC_ADDRESS[7:0];
      endcase
    end else begin
      case (idx[1:0])
        2'd0:    own_b = ACCELERATOR_IP_ADDRESS[31:24];
        2'd1:    own_b = ACCELERATOR_IP_ADDRESS[23:16];
        2'd2:    own_b = ACCELERATOR_IP_ADDRESS[15:8];
        default: own_b = ACCELERATOR_IP_ADDRESS[7:0];
      endcase
    end
    addr_byte = ((sec == ETH_HDR) && (idx < 6'd6)) ||
                ((sec == IP_HDR) && (idx >= 6'd16) && (idx <= 6'd19));
    cand_in   = ((idx == 6'd0) || (idx == 6'd16)) ? 2'b11 : cand_q;
    cand_byte = {cand_in[1] && (rx.MAC_DATA_IN == own_b),
                 cand_in[0] && ACCEPT_BROADCAST && (rx.MAC_DATA_IN == 8'hFF)};
  end

`ifdef IP_RX_CHECKSUM_EN
  logic [15:0] csum_q, csum_in, csum_nxt;
  logic [16:0] csum_sum;
  logic [7:0]  csum_hi_q;

  // One's-complement running sum of the IP header words, folded carry each word
  always_comb begin
    csum_in  = (idx == 6'd1) ? 16'h0000 : csum_q;
    csum_sum = {1'b0, csum_in} + {1'b0, csum_hi_q, rx.MAC_DATA_IN};
    csum_nxt = csum_sum[15:0] + {15'd0, csum_sum[16]};
    csum_bad = (sec == IP_HDR) && (idx == 6'd19) && (csum_nxt != 16'hFFFF);
  end

  // Checksum accumulator: even bytes latch the high half, odd bytes add the word
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      csum_q    <= '0;
      csum_hi_q <= '0;
    end else if (beat && (sec == IP_HDR)) begin
      if (!idx[0]) csum_hi_q <= rx.MAC_DATA_IN;
      else         csum_q    <= csum_nxt;
    end
  end
`else
  assign csum_bad = 1'b0;
`endif

  // State register
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      cand_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cand_q  <= cand_d;
    end
  end

  // Next-state: field checks, frame boundaries and drop decisions
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cand_d    = cand_q;
    bad       = 1'b0;
    hold_load = 1'b0;
    drop_d    = 1'b0;
    if (state_q == HOLD) begin
      if (rx.MESSAGE_ACCEPT) state_d = IDLE;
    end else if (beat) begin
      if (addr_byte) begin
        cand_d = cand_byte;
        bad    = (cand_byte == 2'b00);
      end
      if (sec == ETH_HDR && idx == 6'd12) bad = (rx.MAC_DATA_IN != ETHERTYPE[15:8]);
      if (sec == ETH_HDR && idx == 6'd13) bad = (rx.MAC_DATA_IN != ETHERTYPE[7:0]);
      if (sec == IP_HDR  && idx == 6'd0)  bad = (rx.MAC_DATA_IN != 8'h45);
      if (sec == IP_HDR  && idx == 6'd9)  bad = (rx.MAC_DATA_IN != IP_PROTOCOL);
      if (csum_bad) bad = 1'b1;

      if (sec == IDLE) begin
        state_d = IDLE;
      end else if (sec == DROP) begin
        if (rx.MAC_DATA_LAST) begin
          state_d = IDLE;
          drop_d  = 1'b1;
        end
      end else if (bad) begin
        state_d = rx.MAC_DATA_LAST ? IDLE : DROP;
        drop_d  = rx.MAC_DATA_LAST;
      end else if (sec == USER_DATA && idx >= 6'd1 && rx.MAC_DATA_LAST) begin
        state_d   = HOLD;
        hold_load = 1'b1;
      end else if (rx.MAC_DATA_LAST) begin
        state_d = IDLE;
        drop_d  = 1'b1;
      end else if (sec == ETH_HDR && idx == 6'd13) begin
        state_d = IP_HDR;
      end else if (sec == IP_HDR && idx == 6'd19) begin
        state_d = USER_DATA;
      end else begin
        state_d = sec;
      end
      // Counter holds the index of the next byte within the section; entering
      // ETH_HDR from IDLE leaves it at 1 because that beat was byte 0.
      cnt_d = ((state_d == sec) && (sec != IDLE) && (sec != DROP)) ? idx_inc : 6'd0;
    end
  end

  // Outputs
  always_comb begin
    rx.MAC_DATA_READY     = !areset && (state_q != HOLD);
    rx.MESSAGE_VALID      = (state_q == HOLD);
    rx.PACKET_DROPPED     = drop_q;
    rx.SENDER_MAC_ADDRESS = smac_q;
    rx.SENDER_IP_ADDRESS  = sip_q;
    rx.SENDER_MESSAGE     = msg_q;
  end

  // Capture shadows while parsing; publish them only when a frame is accepted
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      smac_sh_q <= '0;
      sip_sh_q  <= '0;
      p0_q      <= '0;
      p1_q      <= '0;
      smac_q    <= '0;
      sip_q     <= '0;
      msg_q     <= '0;
      drop_q    <= 1'b0;
    end else begin
      drop_q <= drop_d;
      if (beat) begin
        if (sec == ETH_HDR && idx >= 6'd6 && idx <= 6'd11) smac_sh_q <= {smac_sh_q[39:0], rx.MAC_DATA_IN};
        if (sec == IP_HDR && idx >= 6'd12 && idx <= 6'd15) sip_sh_q  <= {sip_sh_q[23:0], rx.MAC_DATA_IN};
        if (sec == USER_DATA && idx == 6'd0) p0_q <= rx.MAC_DATA_IN[1:0];
        if (sec == USER_DATA && idx == 6'd1) p1_q <= rx.MAC_DATA_IN;
      end
      if (hold_load) begin
        smac_q <= smac_sh_q;
        sip_q  <= sip_sh_q;
        msg_q  <= (idx == 6'd1) ? {p0_q, rx.MAC_DATA_IN} : {p0_q, p1_q};
      end
    end
  end

endmodule

// File: tb/tb_ip_packet_rx.sv
module tb_ip_packet_rx;
  localparam logic [47:0] OWN_MAC = 48'h0200_00AA_BBCC;
  localparam logic [31:0] OWN_IP  = 32'hC0A8_0110;
  localparam logic [47:0] SRC_MAC = 48'h0A0B_0C0D_0E0F;

  logic aclk = 1'b0;
  logic areset = 1'b1;
  ip_packet_rx_if bus();

  ip_packet_rx dut (
    .aclk(aclk), .areset(areset),
    .ACCELERATOR_IP_ADDRESS(OWN_IP), .ACCELERATOR_MAC_ADDRESS(OWN_MAC),
    .rx(bus)
  );

  always #5 aclk = ~aclk;

  int tests = 0, fails = 0, drop_cnt = 0, exp_drops = 0;
  logic [7:0] frm [$];

  always @(negedge aclk) if (bus.PACKET_DROPPED) drop_cnt++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] hdr_sum();
    int s = 0;
    for (int i = 0; i < 10; i++) s += {frm[14+2*i], frm[15+2*i]};
    while (s > 32'hFFFF) s = (s & 32'hFFFF) + (s >> 16);
    return s[15:0];
  endfunction

  task automatic fix_csum();
    logic [15:0] c;
    frm[24] = 8'h00; frm[25] = 8'h00;
    c = ~hdr_sum();
    frm[24] = c[15:8]; frm[25] = c[7:0];
  endtask

  task automatic build(input logic [47:0] smac, input logic [31:0] sip, input logic [7:0] p0, p1, input int npad);
    logic [7:0] ip [20];
    frm.delete();
    for (int i = 5; i >= 0; i--) frm.push_back(OWN_MAC[8*i +: 8]);
    for (int i = 5; i >= 0; i--) frm.push_back(smac[8*i +: 8]);
    frm.push_back(8'h08); frm.push_back(8'h00);
    ip = '{8'h45, 8'h00, 8'h00, 8'h16, 8'h12, 8'h34, 8'h40, 8'h00, 8'h40, 8'hFD,
           8'h00, 8'h00, sip[31:24], sip[23:16], sip[15:8], sip[7:0],
           OWN_IP[31:24], OWN_IP[23:16], OWN_IP[15:8], OWN_IP[7:0]};
    for (int i = 0; i < 20; i++) frm.push_back(ip[i]);
    frm.push_back(p0); frm.push_back(p1);
    for (int i = 0; i < npad; i++) frm.push_back(8'($urandom));
    fix_csum();
  endtask

  task automatic mutate(input int kind, input int trunc_len);
    case (kind)
      1: frm[3] = frm[3] ^ 8'h01;
      2: begin for (int i = 0; i < 6; i++) frm[i] = 8'hFF; end
      3: frm[13] = 8'h06;
      4: begin frm[14] = 8'h46; fix_csum(); end
      5: begin frm[23] = 8'h06; fix_csum(); end
      6: begin frm[30] = 8'hC0; frm[31] = 8'hA8; frm[32] = 8'h01; frm[33] = 8'h99; fix_csum(); end
      7: begin for (int i = 30; i < 34; i++) frm[i] = 8'hFF; fix_csum(); end
      8: while (frm.size() > trunc_len) void'(frm.pop_back());
      9: frm[24] = frm[24] ^ 8'h10;
      default: ;
    endcase
  endtask

  // Frame-level reference: a frame is delivered iff it is long enough and every field rule holds
  function automatic bit model_ok();
    logic [47:0] dm = '0;
    logic [31:0] di = '0;
    if (frm.size() < 36) return 1'b0;
    for (int i = 0; i < 6; i++) dm = {dm[39:0], frm[i]};
    for (int i = 30; i < 34; i++) di = {di[23:0], frm[i]};
    if (dm != OWN_MAC && dm != 48'hFFFF_FFFF_FFFF) return 1'b0;
    if ({frm[12], frm[13]} != 16'h0800) return 1'b0;
    if (frm[14] != 8'h45 || frm[23] != 8'hFD) return 1'b0;
    if (di != OWN_IP && di != 32'hFFFF_FFFF) return 1'b0;
`ifdef IP_RX_CHECKSUM_EN
    if (hdr_sum() != 16'hFFFF) return 1'b0;
`endif
    return 1'b1;
  endfunction

  task automatic send(input bit with_last, input bit gaps);
    for (int i = 0; i < frm.size(); i++) begin
      int n = 0;
      if (gaps && $urandom_range(0, 3) == 0) begin
        bus.MAC_DATA_VALID = 1'b0;
        @(negedge aclk);
      end
      while (!bus.MAC_DATA_READY && n < 50) begin @(negedge aclk); n++; end
      if (n >= 50) begin
        tests++; fails++;
        $display("FAIL ready_timeout: got 0 expected 1");
      end
      bus.MAC_DATA_IN    = frm[i];
      bus.MAC_DATA_VALID = 1'b1;
      bus.MAC_DATA_FIRST = (i == 0);
      bus.MAC_DATA_LAST  = with_last && (i == frm.size() - 1);
      @(negedge aclk);
    end
    bus.MAC_DATA_VALID = 1'b0;
    bus.MAC_DATA_FIRST = 1'b0;
    bus.MAC_DATA_LAST  = 1'b0;
  endtask

  task automatic run_frame(input string nm, input bit exp_ok, input logic [9:0] exp_msg,
                           input logic [31:0] exp_sip, input logic [47:0] exp_smac,
                           input int hold, input bit gaps);
    send(1'b1, gaps);
    check({nm, "_valid"}, bus.MESSAGE_VALID, exp_ok);
    check({nm, "_dropped"}, bus.PACKET_DROPPED, !exp_ok);
    if (exp_ok) begin
      check({nm, "_msg"}, bus.SENDER_MESSAGE, exp_msg);
      check({nm, "_sip"}, bus.SENDER_IP_ADDRESS, exp_sip);
      check({nm, "_smac"}, bus.SENDER_MAC_ADDRESS, exp_smac);
      for (int c = 0; c < hold; c++) begin
        @(negedge aclk);
        check({nm, "_hold_ready"}, bus.MAC_DATA_READY, 1'b0);
        check({nm, "_hold_valid"}, bus.MESSAGE_VALID, 1'b1);
        check({nm, "_hold_msg"}, {bus.SENDER_MESSAGE, bus.SENDER_IP_ADDRESS}, {exp_msg, exp_sip});
      end
      bus.MESSAGE_ACCEPT = 1'b1;
      @(negedge aclk);
      bus.MESSAGE_ACCEPT = 1'b0;
      check({nm, "_after_accept"}, {bus.MESSAGE_VALID, bus.MAC_DATA_READY}, 2'b01);
    end else begin
      exp_drops++;
      @(negedge aclk);
      check({nm, "_pulse_end"}, bus.PACKET_DROPPED, 1'b0);
    end
  endtask

  typedef struct {
    int          kind;
    logic [31:0] sip;
    logic [7:0]  p0, p1;
    int          npad;
    bit          exp_ok;
    logic [9:0]  exp_msg;
  } vec_t;

  initial begin
    vec_t tbl [11];
    tbl[0]  = '{0,  32'hC0A80105, 8'h02, 8'hA5, 0,  1'b1, 10'h2A5};
    tbl[1]  = '{1,  32'hC0A80105, 8'h01, 8'h23, 0,  1'b0, 10'h000};
    tbl[2]  = '{2,  32'h0A000001, 8'hF3, 8'h5A, 0,  1'b1, 10'h35A};
    tbl[3]  = '{3,  32'hC0A80105, 8'h01, 8'h01, 0,  1'b0, 10'h000};
    tbl[4]  = '{4,  32'hC0A80105, 8'h01, 8'h01, 0,  1'b0, 10'h000};
    tbl[5]  = '{5,  32'hC0A80105, 8'h01, 8'h01, 0,  1'b0, 10'h000};
    tbl[6]  = '{6,  32'hC0A80105, 8'h02, 8'hA5, 0,  1'b0, 10'h000};
    tbl[7]  = '{7,  32'hC0A80107, 8'hFF, 8'hFF, 0,  1'b1, 10'h3FF};
    tbl[8]  = '{8,  32'hC0A80105, 8'h01, 8'h01, 0,  1'b0, 10'h000};
`ifdef IP_RX_CHECKSUM_EN
    tbl[9]  = '{9,  32'hC0A80108, 8'h00, 8'h7E, 0,  1'b0, 10'h000};
`else
    tbl[9]  = '{9,  32'hC0A80108, 8'h00, 8'h7E, 0,  1'b1, 10'h07E};
`endif
    tbl[10] = '{0,  32'hAC100002, 8'h01, 8'h00, 10, 1'b1, 10'h100};

    bus.MAC_DATA_IN = '0; bus.MAC_DATA_VALID = 1'b0; bus.MAC_DATA_FIRST = 1'b0;
    bus.MAC_DATA_LAST = 1'b0; bus.MESSAGE_ACCEPT = 1'b0;
    repeat (3) @(negedge aclk);
    check("reset_outputs", {bus.MESSAGE_VALID, bus.PACKET_DROPPED, bus.MAC_DATA_READY}, 3'b000);
    check("reset_sender", {bus.SENDER_MAC_ADDRESS, bus.SENDER_MESSAGE}, 58'h0);
    areset = 1'b0;
    @(negedge aclk);
    check("ready_after_reset", bus.MAC_DATA_READY, 1'b1);

    // Table: one frame variant per row
    for (int r = 0; r < 11; r++) begin
      build(SRC_MAC, tbl[r].sip, tbl[r].p0, tbl[r].p1, tbl[r].npad);
      mutate(tbl[r].kind, 22);
      run_frame($sformatf("tbl%0d", r), tbl[r].exp_ok, tbl[r].exp_msg, tbl[r].sip, SRC_MAC, 0, 1'b0);
    end

    // Result held for 10 cycles without accept, then the next frame must still parse
    build(SRC_MAC, 32'hC0A80105, 8'h02, 8'hA5, 0);
    run_frame("hold10", 1'b1, 10'h2A5, 32'hC0A80105, SRC_MAC, 10, 1'b0);
    build(48'h1122_3344_5566, 32'hC0A80109, 8'h03, 8'h0F, 0);
    run_frame("after_hold", 1'b1, 10'h30F, 32'hC0A80109, 48'h1122_3344_5566, 0, 1'b0);

    // LAST on IP byte 7, immediately followed by a good frame
    build(SRC_MAC, 32'hC0A80105, 8'h01, 8'h01, 0);
    mutate(8, 22);
    run_frame("early_last", 1'b0, 10'h0, 32'h0, 48'h0, 0, 1'b0);
    build(SRC_MAC, 32'hC0A80106, 8'h02, 8'h11, 0);
    run_frame("b2b_good", 1'b1, 10'h211, 32'hC0A80106, SRC_MAC, 0, 1'b0);

    // FIRST reasserted when the old frame sits at user byte 0
    build(SRC_MAC, 32'hC0A80155, 8'h01, 8'h11, 0);
    mutate(8, 34);
    send(1'b0, 1'b0);
    build(48'h0A0B_0C0D_0E10, 32'hC0A80166, 8'h00, 8'hC3, 0);
    run_frame("restart", 1'b1, 10'h0C3, 32'hC0A80166, 48'h0A0B_0C0D_0E10, 0, 1'b0);

    // Reset mid-frame and during HOLD
    build(SRC_MAC, 32'hC0A80105, 8'h01, 8'h01, 0);
    mutate(8, 20);
    send(1'b0, 1'b0);
    areset = 1'b1; #1;
    check("rst_midframe", {bus.MESSAGE_VALID, bus.PACKET_DROPPED, bus.MAC_DATA_READY}, 3'b000);
    @(negedge aclk); areset = 1'b0;
    build(SRC_MAC, 32'hC0A80105, 8'h02, 8'hA5, 0);
    send(1'b1, 1'b0);
    check("pre_rst_hold", bus.MESSAGE_VALID, 1'b1);
    areset = 1'b1; #1;
    check("rst_in_hold", {bus.MESSAGE_VALID, bus.SENDER_MESSAGE}, 11'h0);
    @(negedge aclk); areset = 1'b0;
    @(negedge aclk);
    build(SRC_MAC, 32'hC0A80104, 8'h01, 8'h02, 0);
    run_frame("after_rst", 1'b1, 10'h102, 32'hC0A80104, SRC_MAC, 0, 1'b0);

    // Randomized frames against the frame-level model
    for (int n = 0; n < 60; n++) begin
      logic [47:0] sm;
      logic [31:0] si;
      bit          ok;
      sm = {16'($urandom), 32'($urandom)};
      si = 32'($urandom);
      build(sm, si, 8'($urandom), 8'($urandom), $urandom_range(0, 12));
      mutate($urandom_range(0, 10), $urandom_range(1, 35));
      ok = model_ok();
      run_frame($sformatf("rnd%0d", n), ok,
                ok ? {frm[34][1:0], frm[35]} : 10'h0,
                ok ? {frm[26], frm[27], frm[28], frm[29]} : 32'h0,
                ok ? {frm[6], frm[7], frm[8], frm[9], frm[10], frm[11]} : 48'h0,
                $urandom_range(0, 3), 1'b1);
    end

    repeat (3) @(negedge aclk);
    check("drop_pulse_count", drop_cnt, exp_drops);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
